pipe_if: RTL and testbench
==========================

# pipe_if

Instruction-fetch stage of the external-RAM five-stage MIPS pipeline. It owns the PC and fetches from an external instruction memory through a req/ack handshake. It loads the IF/ID pipeline register (`pc_id`, `instr`) that feeds the decode stage. It applies the decode stage's `stall` and `pcsource`/target outputs, with one architectural branch delay slot, and raises `fetch_busy` to freeze the rest of the pipeline while memory is slow.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: address of the first fetch after reset.
- `NOP`, 32'h0000_0000: value loaded into `instr` on reset (sll $0,$0,0).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `stall`  in  1  load-use hazard from decode: hold the PC and IF/ID.
- `pcsource`  in  2  next-PC select for the instruction in ID:
  - 00: PC+4.
  - 01: `pc_beqbne`.
  - 10: `rd1_id` (jr).
  - 11: {`pc_id`[31:28], `index28`}.
- `pc_beqbne`  in  32  branch target from decode.
- `rd1_id`  in  32  forwarded rs value from decode (jr target).
- `index28`  in  28  jump index shifted left by 2, from decode.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals the PC.
- `imem_ack`  in  1  memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction.
- `pc_id`  out  32  IF/ID register: PC+4 of the instruction in ID.
- `instr`  out  32  IF/ID register: the instruction in ID.
- `fetch_busy`  out  1  global freeze request; high while a fetch is outstanding and not yet acknowledged.

## Operation
- Registers:
  - `pc` (32).
  - `ibuf` (32), which holds an acked instruction while `stall` is high.
  - 2-bit state.
  - `pc_id`, `instr`.
- States:
  - BOOT: `imem_req`=0, always moves to FETCH.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - HELD: `imem_req`=0, the instruction is held in `ibuf`.
- `next_pc` is selected by `pcsource`:
  - 00: `pc`+4, modulo 2^32.
  - 01: `pc_beqbne`.
  - 10: `rd1_id`.
  - 11: {`pc_id`[31:28], `index28`}.
  - The target comes from the instruction currently in ID. The instruction being fetched is its delay slot and is always executed; there is no flush.
- FETCH with `imem_ack`=1 and `stall`=0 (advance):
  - `pc_id` <= `pc`+4, `instr` <= `imem_rdata`, `pc` <= `next_pc`.
  - Stay in FETCH.
- FETCH with `imem_ack`=1 and `stall`=1:
  - `ibuf` <= `imem_rdata`.
  - Go to HELD. `pc` and IF/ID are unchanged.
- FETCH with `imem_ack`=0: nothing changes and `fetch_busy`=1.
- HELD with `stall`=0 (advance):
  - `pc_id` <= `pc`+4, `instr` <= `ibuf`, `pc` <= `next_pc`.
  - Go to FETCH.
- HELD with `stall`=1: hold.
- `fetch_busy` = (state==FETCH) & ~`imem_ack`. It is combinational and is 0 in BOOT and HELD.
- While `fetch_busy`=1 the rest of the pipeline is frozen. `stall`, `pcsource` and the targets are therefore stable until the ack arrives.
- `imem_ack` is ignored whenever `imem_req`=0.

## Timing
- Reset (`rst`=0 at an edge):
  - `pc`=RESET_PC, `pc_id`=0, `instr`=NOP, `ibuf`=0, state=BOOT.
  - `imem_req`=0 and `fetch_busy`=0 from the cycle after that edge.
- First request: `imem_req` rises in the cycle after the first edge with `rst`=1.
- Handshake:
  - `imem_addr` is stable while `imem_req`=1 until an edge with `imem_ack`=1.
  - The ack may arrive combinationally in the same cycle as the request (zero wait states).
- Throughput: with zero-wait memory and no stall, one instruction per cycle. `imem_req` stays high continuously and the address changes every cycle.
- Latency: a request acked after N wait cycles loads `instr` at the edge ending cycle N.
- Reset mid-fetch (`rst`=0 with the request outstanding or in HELD):
  - The request is dropped and `ibuf` is discarded.
  - Memory must tolerate `imem_req` falling without an ack.
- Ack coinciding with stall: the instruction is captured in `ibuf` and no refetch is issued.
- Stall arriving while the fetch is not yet acked: no effect until the ack, then the FETCH rules apply.
- PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.

## Test plan
- **Reset and boot.** Hold `rst`=0 for 3 cycles, then release; memory acks at zero wait.
  - `imem_req`=0 during reset and BOOT, then `imem_addr`=0,4,8 on consecutive cycles.
  - `instr` follows the returned data one per cycle; `pc_id`=4,8,12.
- **Wait states.** Ack delayed 2 cycles on address 0x10.
  - `fetch_busy`=1 for exactly 2 cycles and `imem_addr` is held at 0x10.
  - `instr` is updated at the ack edge.
- **Branch with delay slot.**
  - Stimulus: beq in ID, `pc_id`=0x24, `pcsource`=01, `pc_beqbne`=0x40.
  - Required response: the delay slot at 0x24 enters ID and the next `imem_addr`=0x40.
- **Jump and jr.**
  - `pcsource`=11 with `pc_id`=0x9000_0008 and `index28`=0x0000_100 gives next address 0x9000_0100.
  - `pcsource`=10 with `rd1_id`=0x1234_5678 gives 0x1234_5678.
- **Stall on ack.**
  - `stall`=1 in the ack cycle of address 0x30 (data 0xAABBCCDD) and held 3 cycles.
  - `imem_req`=0 in HELD and IF/ID is unchanged.
  - On release, `instr`=0xAABBCCDD, `pc_id`=0x34, and the next request is to 0x34. No duplicate fetch of 0x30.
- **Reset mid-operation.**
  - Stimulus: `rst`=0 while in HELD with a buffered instruction.
  - Required response: `instr`=NOP, `pc_id`=0, the buffer is lost, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/pipe_if_if.sv
// Instruction-memory request/ack channel between the fetch stage (master)
// and external instruction RAM (slave).
interface pipe_if_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pipe_if.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// loads the IF/ID register, honouring decode stall and one branch delay slot.
module pipe_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc_beqbne,
    input  logic [31:0] rd1_id,
    input  logic [27:0] index28,
    pipe_if_if.master   imem,
    output logic [31:0] pc_id,
    output logic [31:0] instr,
    output logic        fetch_busy
);
    typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HELD = 2'd2} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] ibuf, ibuf_n;
    logic [31:0] pc_id_n, instr_n;
    logic [31:0] pc_plus4, next_pc;

    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = pc;

    // Target belongs to the instruction already in ID; the word being fetched
    // now is its delay slot, so it is never squashed.
    always_comb begin
        next_pc = pc_plus4;
        case (pcsource)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = pc_beqbne;
            2'b10:   next_pc = rd1_id;
            default: next_pc = {pc_id[31:28], index28};
        endcase
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        ibuf_n        = ibuf;
        pc_id_n       = pc_id;
        instr_n       = instr;
        imem.imem_req = 1'b0;
        fetch_busy    = 1'b0;
        case (state)
            BOOT: state_n = FETCH;
            FETCH: begin
                imem.imem_req = 1'b1;
                if (!imem.imem_ack) begin
                    fetch_busy = 1'b1;
                end else if (stall) begin
                    // park the word so the stall release needs no refetch
                    ibuf_n  = imem.imem_rdata;
                    state_n = HELD;
                end else begin
                    pc_id_n = pc_plus4;
                    instr_n = imem.imem_rdata;
                    pc_n    = next_pc;
                end
            end
            HELD: begin
                if (!stall) begin
                    pc_id_n = pc_plus4;
                    instr_n = ibuf;
                    pc_n    = next_pc;
                    state_n = FETCH;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
            ibuf  <= 32'h0;
            pc_id <= 32'h0;
            instr <= NOP;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ibuf  <= ibuf_n;
            pc_id <= pc_id_n;
            instr <= instr_n;
        end
    end
endmodule

// File: tb/tb_pipe_if.sv
// Directed test-plan scenarios followed by randomized traffic, all checked
// against a transaction-level model of the fetch stage.
module tb_pipe_if;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] pc_beqbne = 32'h0;
    logic [31:0] rd1_id = 32'h0;
    logic [27:0] index28 = 28'h0;
    logic [31:0] pc_id, instr;
    logic        fetch_busy;

    pipe_if_if imem ();

    pipe_if dut (
        .clk(clk), .rst(rst), .stall(stall), .pcsource(pcsource),
        .pc_beqbne(pc_beqbne), .rd1_id(rd1_id), .index28(index28),
        .imem(imem), .pc_id(pc_id), .instr(instr), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: a fetch is outstanding unless booting or a word is parked
    bit          m_boot;
    logic [31:0] m_pc, m_pc_id, m_instr;
    logic [31:0] m_buf[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h30) return 32'hAABB_CCDD;
        return a * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    function automatic bit m_req();
        return !m_boot && m_buf.size() == 0;
    endfunction

    task automatic m_advance(input logic [31:0] w, input logic [1:0] ps,
                             input logic [31:0] bt, input logic [31:0] jr,
                             input logic [27:0] ix);
        logic [31:0] tgt;
        case (ps)
            2'b00:   tgt = m_pc + 32'd4;
            2'b01:   tgt = bt;
            2'b10:   tgt = jr;
            default: tgt = {m_pc_id[31:28], ix};
        endcase
        m_pc_id = m_pc + 32'd4;
        m_instr = w;
        m_pc    = tgt;
    endtask

    // one clock cycle: check outputs, drive inputs, then apply the edge to the model
    task automatic step(input bit r, input bit a, input bit s, input logic [1:0] ps,
                        input logic [31:0] bt, input logic [31:0] jr, input logic [27:0] ix);
        logic [31:0] d;
        @(negedge clk);
        chk("req", {31'h0, imem.imem_req}, {31'h0, m_req()});
        if (m_req()) chk("addr", imem.imem_addr, m_pc);
        chk("pc_id", pc_id, m_pc_id);
        chk("instr", instr, m_instr);
        d = mem_word(m_pc);
        rst = r; imem.imem_ack = a; imem.imem_rdata = d; stall = s;
        pcsource = ps; pc_beqbne = bt; rd1_id = jr; index28 = ix;
        #1;
        chk("busy", {31'h0, fetch_busy}, {31'h0, m_req() && !a});
        if (!r) begin
            m_boot = 1'b1; m_buf.delete();
            m_pc = 32'h0; m_pc_id = 32'h0; m_instr = 32'h0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_buf.size() == 0) begin
            if (a) begin
                if (s) m_buf.push_back(d);
                else   m_advance(d, ps, bt, jr, ix);
            end
        end else if (!s) begin
            m_advance(m_buf.pop_front(), ps, bt, jr, ix);
        end
    endtask

    task automatic go(input bit a, input bit s);
        step(1'b1, a, s, 2'b00, 32'h0, 32'h0, 28'h0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        imem.imem_ack = 1'b0;
        imem.imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        m_boot = 1'b1; m_pc = 32'h0; m_pc_id = 32'h0; m_instr = 32'h0;

        // reset and boot
        step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 28'h0);
        settle();
        chk("rst_req", {31'h0, imem.imem_req}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc_id", pc_id, 32'h0);
        go(1'b1, 1'b0);
        settle();
        chk("boot_addr0", imem.imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            go(1'b1, 1'b0);
            settle();
            chk("seq_pc_id", pc_id, 32'(4 * (i + 1)));
            chk("seq_instr", instr, mem_word(32'(4 * i)));
        end
        go(1'b1, 1'b0);

        // two wait states at 0x10
        for (int i = 0; i < 2; i++) begin
            go(1'b0, 1'b0);
            chk("wait_busy", {31'h0, fetch_busy}, 32'h1);
            chk("wait_addr", imem.imem_addr, 32'h10);
        end
        go(1'b1, 1'b0);
        settle();
        chk("wait_instr", instr, mem_word(32'h10));
        chk("wait_pc_id", pc_id, 32'h14);

        // branch with delay slot
        repeat (4) go(1'b1, 1'b0);
        settle();
        chk("br_pc_id", pc_id, 32'h24);
        step(1'b1, 1'b1, 1'b0, 2'b01, 32'h40, 32'h0, 28'h0);
        settle();
        chk("br_slot", instr, mem_word(32'h24));
        chk("br_addr", imem.imem_addr, 32'h40);

        // jump and jr
        step(1'b1, 1'b1, 1'b0, 2'b10, 32'h0, 32'h9000_0004, 28'h0);
        go(1'b1, 1'b0);
        settle();
        chk("j_pc_id", pc_id, 32'h9000_0008);
        step(1'b1, 1'b1, 1'b0, 2'b11, 32'h0, 32'h0, 28'h000_0100);
        settle();
        chk("j_addr", imem.imem_addr, 32'h9000_0100);
        step(1'b1, 1'b1, 1'b0, 2'b10, 32'h0, 32'h1234_5678, 28'h0);
        settle();
        chk("jr_addr", imem.imem_addr, 32'h1234_5678);

        // stall on ack at 0x30
        step(1'b1, 1'b1, 1'b0, 2'b10, 32'h0, 32'h30, 28'h0);
        go(1'b1, 1'b1);
        repeat (2) begin
            go(1'b1, 1'b1);
            chk("held_req", {31'h0, imem.imem_req}, 32'h0);
            chk("held_instr", instr, mem_word(32'h1234_5678));
        end
        go(1'b1, 1'b0);
        settle();
        chk("rel_instr", instr, 32'hAABB_CCDD);
        chk("rel_pc_id", pc_id, 32'h34);
        chk("rel_addr", imem.imem_addr, 32'h34);
        chk("rel_req", {31'h0, imem.imem_req}, 32'h1);

        // reset while held
        go(1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 28'h0);
        settle();
        chk("mid_instr", instr, 32'h0);
        chk("mid_pc_id", pc_id, 32'h0);
        go(1'b1, 1'b0);
        go(1'b1, 1'b0);
        settle();
        chk("mid_pc_id2", pc_id, 32'h4);
        chk("mid_instr2", instr, mem_word(32'h0));

        // PC+4 wrap
        step(1'b1, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFC, 28'h0);
        go(1'b1, 1'b0);
        settle();
        chk("wrap_pc_id", pc_id, 32'h0);
        chk("wrap_addr", imem.imem_addr, 32'h0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) != 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                 $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                 28'($urandom) & 28'hFFF_FFFC);
        end
        go(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
